// File: rtl/sum_window_pkg.sv
// rtl/sum_window_pkg.sv - shared defaults and width helpers for the sum window accumulator
package sum_window_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_WINDOW     = 4;
   localparam int DEF_SEQ_WIDTH  = 8;

   // Wide enough that WINDOW full-scale samples can never overflow the total.
   function automatic int acc_width(input int data_width, input int window);
      return data_width + $clog2(window);
   endfunction

endpackage

// File: rtl/sum_window_out_reg.sv
// rtl/sum_window_out_reg.sv - valid/ready holding register for a finished window total
module sum_window_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             vld,
   input  logic             rd,
   output logic             free
);

   assign free = ~vld | rd;

   // A load in the same cycle as a drain keeps vld high, so no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         vld <= 1'b0;
      end else if (load) begin
         q   <= d;
         vld <= 1'b1;
      end else if (rd) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/sum_window_accumulator.sv
// rtl/sum_window_accumulator.sv - sums WINDOW accepted samples and hands out sequenced totals
module sum_window_accumulator
   import sum_window_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WINDOW     = DEF_WINDOW,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, WINDOW),
   parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_vld,
   output logic                  din_rd,
   output logic [ACC_WIDTH-1:0]  dout,
   output logic [SEQ_WIDTH-1:0]  dout_seq,
   output logic                  dout_vld,
   input  logic                  dout_rd
);

   localparam int CNT_WIDTH = $clog2(WINDOW);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);

   logic [ACC_WIDTH-1:0]           acc;
   logic [ACC_WIDTH-1:0]           sum;
   logic [CNT_WIDTH-1:0]           cnt;
   logic [SEQ_WIDTH-1:0]           seq;
   logic                           free;
   logic                           accept;
   logic                           load;
   logic [SEQ_WIDTH+ACC_WIDTH-1:0] out_q;

   // Samples are only taken when a completed total could be handed off.
   assign din_rd = free & ~clr;
   assign accept = din_vld & din_rd;
   assign load   = accept & (cnt == CNT_LAST);
   assign sum    = acc + ACC_WIDTH'(din);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         seq <= '0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         cnt <= '0;
         seq <= seq + 1'b1;
      end else if (accept) begin
         acc <= sum;
         cnt <= cnt + 1'b1;
      end
   end

   sum_window_out_reg #(
      .WIDTH(SEQ_WIDTH + ACC_WIDTH)
   ) u_out_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .d    ({seq, sum}),
      .q    (out_q),
      .vld  (dout_vld),
      .rd   (dout_rd),
      .free (free)
   );

   assign dout_seq = out_q[SEQ_WIDTH+ACC_WIDTH-1:ACC_WIDTH];
   assign dout     = out_q[ACC_WIDTH-1:0];

endmodule
